// File: rtl/tone_gen_pkg.sv
// -----------------------------------------------------------------------------
// tone_gen_pkg
// Shared definitions for the multi-channel tone generator:
//   - channel state encoding (IDLE / PLAY / RELEASE)
//   - default values for the top-level parameters
//   - signed saturation helper used by the optional mix path
// -----------------------------------------------------------------------------
package tone_gen_pkg;

    // Channel state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Parameter defaults
    localparam int NUM_CH_DEF    = 32'd2;
    localparam int DIV_W_DEF     = 32'd22;
    localparam int AMP_W_DEF     = 32'd16;
    localparam int REL_TICKS_DEF = 32'd1250000;

    // Clamp a signed value into the two's complement range of out_w bits.
    // The caller keeps the low out_w bits of the result.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] val,
        input int unsigned        out_w
    );
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (val > max_v) begin
            sat_signed = max_v;
        end else if (val < min_v) begin
            sat_signed = min_v;
        end else begin
            sat_signed = val;
        end
    endfunction

endpackage

// File: rtl/tone_channel.sv
// -----------------------------------------------------------------------------
// tone_channel
// One square-wave note channel: half-period divider, IDLE/PLAY/RELEASE state
// machine with halving-decay release, glitch-free retune, registered output.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   note_div  in   [DIV_W]  toggle period minus 1; 0 = no note
//   key_on    in   key held (level)
//   amp       in   [AMP_W]  peak magnitude, clipped to 2^(AMP_W-1)-1
//   rel_tick  in   one-cycle decay strobe from the shared prescaler
//   audio     out  [AMP_W]  signed sample, 0 while idle
//   active    out  1 while in PLAY or RELEASE
// -----------------------------------------------------------------------------
module tone_channel
    import tone_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int AMP_W = AMP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] note_div,
    input  logic             key_on,
    input  logic [AMP_W-1:0] amp,
    input  logic             rel_tick,
    output logic [AMP_W-1:0] audio,
    output logic             active
);

    localparam int               LVL_W   = AMP_W - 1;
    localparam logic [LVL_W-1:0] LVL_MAX = {LVL_W{1'b1}};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic [DIV_W-1:0] div_q_r;
    logic [DIV_W-1:0] div_q_nxt_s;
    logic             sq_r;
    logic             sq_nxt_s;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;

    logic [LVL_W-1:0] amp_clip_s;
    logic             start_s;
    logic             wrap_s;
    logic             level_zero_s;
    logic [DIV_W-1:0] cnt_adv_s;
    logic             sq_adv_s;

    logic [AMP_W-1:0] mag_s;
    logic [AMP_W-1:0] audio_nxt_s;
    logic             active_nxt_s;
    logic [AMP_W-1:0] audio_r;
    logic             active_r;

    // Clip amplitude, decode key request and free-running oscillator step
    always_comb begin
        amp_clip_s   = amp[AMP_W-1] ? LVL_MAX : amp[LVL_W-1:0];
        start_s      = key_on & (note_div != {DIV_W{1'b0}});
        wrap_s       = (cnt_r == div_q_r);
        level_zero_s = (level_r == {LVL_W{1'b0}});
        cnt_adv_s    = wrap_s ? {DIV_W{1'b0}} : (cnt_r + DIV_W'(1'b1));
        sq_adv_s     = wrap_s ? ~sq_r : sq_r;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a retrigger wins over a same-cycle decay
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (start_s) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (start_s) begin
                    state_nxt_s = ST_PLAY;
                end else if (rel_tick && level_zero_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Divider, square and level update for the current state
    always_comb begin
        cnt_nxt_s   = cnt_r;
        sq_nxt_s    = sq_r;
        level_nxt_s = level_r;
        div_q_nxt_s = div_q_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    div_q_nxt_s = note_div;
                    level_nxt_s = amp_clip_s;
                end else begin
                    level_nxt_s = {LVL_W{1'b0}};
                end
                cnt_nxt_s = {DIV_W{1'b0}};
                sq_nxt_s  = 1'b0;
            end
            ST_PLAY: begin
                level_nxt_s = amp_clip_s;
                // Retune restarts the half-period but keeps the square phase,
                // so a shorter divider can never be overrun by the old count.
                if (start_s && (note_div != div_q_r)) begin
                    div_q_nxt_s = note_div;
                    cnt_nxt_s   = {DIV_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_adv_s;
                    sq_nxt_s  = sq_adv_s;
                end
            end
            ST_RELEASE: begin
                if (start_s) begin
                    div_q_nxt_s = note_div;
                    level_nxt_s = amp_clip_s;
                    cnt_nxt_s   = {DIV_W{1'b0}};
                    sq_nxt_s    = 1'b0;
                end else if (rel_tick && level_zero_s) begin
                    level_nxt_s = {LVL_W{1'b0}};
                    cnt_nxt_s   = {DIV_W{1'b0}};
                    sq_nxt_s    = 1'b0;
                end else begin
                    cnt_nxt_s   = cnt_adv_s;
                    sq_nxt_s    = sq_adv_s;
                    level_nxt_s = rel_tick ? (level_r >> 1) : level_r;
                end
            end
            default: begin
                div_q_nxt_s = {DIV_W{1'b0}};
                level_nxt_s = {LVL_W{1'b0}};
                cnt_nxt_s   = {DIV_W{1'b0}};
                sq_nxt_s    = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {DIV_W{1'b0}};
            sq_r    <= 1'b0;
            level_r <= {LVL_W{1'b0}};
            div_q_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r   <= cnt_nxt_s;
            sq_r    <= sq_nxt_s;
            level_r <= level_nxt_s;
            div_q_r <= div_q_nxt_s;
        end
    end

    // Output decode from the post-edge state so audio is valid on the loading edge
    always_comb begin
        mag_s        = {1'b0, level_nxt_s};
        active_nxt_s = (state_nxt_s != ST_IDLE);
        if (!active_nxt_s) begin
            audio_nxt_s = {AMP_W{1'b0}};
        end else if (sq_nxt_s) begin
            audio_nxt_s = mag_s;
        end else begin
            audio_nxt_s = ~mag_s + AMP_W'(1'b1);
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_r  <= {AMP_W{1'b0}};
            active_r <= 1'b0;
        end else begin
            audio_r  <= audio_nxt_s;
            active_r <= active_nxt_s;
        end
    end

    assign audio  = audio_r;
    assign active = active_r;

endmodule

// File: rtl/tone_gen_multi.sv
// -----------------------------------------------------------------------------
// tone_gen_multi
// N-channel square-wave note generator. Each channel is an independent
// tone_channel; only the release-decay prescaler is shared.
//
// Build option: define TONE_MIX_EN to add audio_mix, the registered and
// saturated sum of all channel samples (one cycle after audio).
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   note_div   in   [NUM_CH*DIV_W]  per-channel toggle period minus 1 (0 = off)
//   key_on     in   [NUM_CH]        key held per channel
//   amp        in   [AMP_W]         shared peak magnitude
//   audio      out  [NUM_CH*AMP_W]  signed sample per channel
//   ch_active  out  [NUM_CH]        channel in PLAY or RELEASE
//   audio_mix  out  [AMP_W]         saturated mix (TONE_MIX_EN only)
// -----------------------------------------------------------------------------
module tone_gen_multi
    import tone_gen_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int DIV_W     = DIV_W_DEF,
    parameter int AMP_W     = AMP_W_DEF,
    parameter int REL_TICKS = REL_TICKS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*DIV_W-1:0] note_div,
    input  logic [NUM_CH-1:0]       key_on,
    input  logic [AMP_W-1:0]        amp,
    output logic [NUM_CH*AMP_W-1:0] audio,
    output logic [NUM_CH-1:0]       ch_active
`ifdef TONE_MIX_EN
    ,
    output logic [AMP_W-1:0]        audio_mix
`endif
);

    localparam int               PRE_W    = $clog2(REL_TICKS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REL_TICKS - 32'sd1);

    logic [PRE_W-1:0] pre_cnt_r;
    logic             rel_tick_s;

    // Decay strobe on the last prescaler count
    always_comb begin
        rel_tick_s = (pre_cnt_r == PRE_LAST);
    end

    // Free-running release prescaler shared by all channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else if (rel_tick_s) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1'b1);
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        tone_channel #(
            .DIV_W (DIV_W),
            .AMP_W (AMP_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .note_div (note_div[gi*DIV_W +: DIV_W]),
            .key_on   (key_on[gi]),
            .amp      (amp),
            .rel_tick (rel_tick_s),
            .audio    (audio[gi*AMP_W +: AMP_W]),
            .active   (ch_active[gi])
        );
    end

`ifdef TONE_MIX_EN
    localparam int SUM_W = AMP_W + $clog2(NUM_CH);

    logic signed [SUM_W-1:0] sum_s;
    logic [AMP_W-1:0]        mix_nxt_s;
    logic [AMP_W-1:0]        audio_mix_r;

    // Sign-extended sum of the registered channel samples, then clamp
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            sum_s = sum_s + SUM_W'($signed(audio[i*AMP_W +: AMP_W]));
        end
        mix_nxt_s = AMP_W'(sat_signed(64'(sum_s), AMP_W));
    end

    // Mix output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_mix_r <= {AMP_W{1'b0}};
        end else begin
            audio_mix_r <= mix_nxt_s;
        end
    end

    assign audio_mix = audio_mix_r;
`endif

endmodule

// File: tb/tb_tone_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_tone_gen_multi
// Self-checking bench for tone_gen_multi (NUM_CH=2, AMP_W=16, REL_TICKS=4).
// A behavioural reference model pushes the expected outputs every clock edge;
// the checker pops and compares them on the falling edge. Directed checks
// cover the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_tone_gen_multi;

    localparam int NUM_CH    = 2;
    localparam int DIV_W     = 22;
    localparam int AMP_W     = 16;
    localparam int REL_TICKS = 4;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_REL  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH*DIV_W-1:0] note_div;
    logic [NUM_CH-1:0]       key_on;
    logic [AMP_W-1:0]        amp;
    logic [NUM_CH*AMP_W-1:0] audio;
    logic [NUM_CH-1:0]       ch_active;
`ifdef TONE_MIX_EN
    logic [AMP_W-1:0]        audio_mix;
`endif

    tone_gen_multi #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .AMP_W     (AMP_W),
        .REL_TICKS (REL_TICKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .note_div  (note_div),
        .key_on    (key_on),
        .amp       (amp),
        .audio     (audio),
        .ch_active (ch_active)
`ifdef TONE_MIX_EN
        ,
        .audio_mix (audio_mix)
`endif
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [NUM_CH*AMP_W-1:0] audio;
        logic [NUM_CH-1:0]       active;
        logic [AMP_W-1:0]        mix;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    int m_state [NUM_CH];
    int m_cnt   [NUM_CH];
    int m_level [NUM_CH];
    int m_div   [NUM_CH];
    bit m_sq    [NUM_CH];
    int m_pre;
    int m_prev_sum;

    function automatic int m_sample(input int c);
        if (m_state[c] == M_IDLE) return 0;
        return m_sq[c] ? m_level[c] : -m_level[c];
    endfunction

    function automatic logic [15:0] m_sat(input int s);
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    function automatic logic [15:0] mag16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

    task automatic m_osc(input int c);
        if (m_cnt[c] == m_div[c]) begin
            m_cnt[c] = 0;
            m_sq[c]  = ~m_sq[c];
        end else begin
            m_cnt[c] = m_cnt[c] + 1;
        end
    endtask

    task automatic m_load(input int c, input int nd, input int a);
        m_state[c] = M_PLAY;
        m_div[c]   = nd;
        m_level[c] = a;
        m_cnt[c]   = 0;
        m_sq[c]    = 1'b0;
    endtask

    // Reference model: advance on every rising edge and queue the expected outputs
    always @(posedge clk) begin
        exp_t e;
        bit   rel;
        int   nd;
        int   a;
        bit   go;
        int   sum;
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_state[c] = M_IDLE;
                m_cnt[c]   = 0;
                m_level[c] = 0;
                m_div[c]   = 0;
                m_sq[c]    = 1'b0;
            end
            m_pre      = 0;
            m_prev_sum = 0;
            e.mix      = 16'h0000;
        end else begin
            e.mix = m_sat(m_prev_sum);
            rel   = (m_pre == REL_TICKS - 1);
            m_pre = rel ? 0 : m_pre + 1;
            a     = (amp > 16'd32767) ? 32767 : int'(amp);
            for (int c = 0; c < NUM_CH; c++) begin
                nd = int'(note_div[c*DIV_W +: DIV_W]);
                go = key_on[c] && (nd != 0);
                case (m_state[c])
                    M_IDLE: begin
                        if (go) m_load(c, nd, a);
                    end
                    M_PLAY: begin
                        m_level[c] = a;
                        if (!go) begin
                            m_state[c] = M_REL;
                            m_osc(c);
                        end else if (nd != m_div[c]) begin
                            m_div[c] = nd;
                            m_cnt[c] = 0;
                        end else begin
                            m_osc(c);
                        end
                    end
                    default: begin
                        if (go) begin
                            m_load(c, nd, a);
                        end else if (rel && m_level[c] == 0) begin
                            m_state[c] = M_IDLE;
                            m_cnt[c]   = 0;
                            m_sq[c]    = 1'b0;
                        end else begin
                            m_osc(c);
                            if (rel) m_level[c] = m_level[c] >> 1;
                        end
                    end
                endcase
            end
        end
        sum = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            e.audio[c*AMP_W +: AMP_W] = 16'(m_sample(c));
            e.active[c]               = (m_state[c] != M_IDLE);
            sum                       = sum + m_sample(c);
        end
        m_prev_sum = sum;
        sb_q.push_back(e);
    end

    // Scoreboard checker on the falling edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("sb_audio", audio, e.audio);
            check_eq("sb_ch_active", ch_active, e.active);
`ifdef TONE_MIX_EN
            check_eq("sb_audio_mix", audio_mix, e.mix);
`endif
        end
    end

    task automatic next_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_div(input int ch, input int val);
        note_div[ch*DIV_W +: DIV_W] = DIV_W'(val);
    endtask

    // Directed stimulus
    initial begin
        bit found;
        bit sq0;
        rst_n    = 1'b0;
        key_on   = 2'b00;
        note_div = '0;
        amp      = 16'h0000;
        next_cyc(3);
        check_eq("reset_audio", audio, 32'h0);
        check_eq("reset_active", ch_active, 2'b00);
        rst_n = 1'b1;

        // Key held with no note stays idle
        key_on = 2'b11;
        amp    = 16'h1000;
        next_cyc(4);
        check_eq("nodiv_active", ch_active, 2'b00);
        check_eq("nodiv_audio", audio, 32'h0);

        // Basic note on channel 0
        key_on = 2'b01;
        set_div(0, 3);
        next_cyc(1);
        check_eq("start_audio0", audio[15:0], 16'hF000);
        check_eq("start_audio1", audio[31:16], 16'h0000);
        check_eq("start_active", ch_active, 2'b01);
        next_cyc(3);
        check_eq("low_half_end", audio[15:0], 16'hF000);
        next_cyc(1);
        check_eq("first_toggle", audio[15:0], 16'h1000);
        next_cyc(12);

        // Retune 3 -> 1 while cnt == 2
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (m_cnt[0] == 2) found = 1'b1;
            else next_cyc(1);
        end
        sq0 = m_sq[0];
        set_div(0, 1);
        next_cyc(1);
        check_eq("retune_hold0", audio[15:0], sq0 ? 16'h1000 : 16'hF000);
        next_cyc(1);
        check_eq("retune_hold1", audio[15:0], sq0 ? 16'h1000 : 16'hF000);
        next_cyc(1);
        check_eq("retune_toggle", audio[15:0], sq0 ? 16'hF000 : 16'h1000);
        next_cyc(8);

        // Second channel alongside, then amplitude clip
        key_on = 2'b11;
        set_div(1, 5);
        next_cyc(14);
        amp = 16'hFFFF;
        next_cyc(1);
        check_eq("clip_mag0", mag16(audio[15:0]), 16'h7FFF);
        check_eq("clip_mag1", mag16(audio[31:16]), 16'h7FFF);
        amp = 16'h1000;
        set_div(0, 3);
        key_on = 2'b01;
        next_cyc(3);

        // Release decay to idle
        key_on = 2'b00;
        next_cyc(70);
        check_eq("release_idle", ch_active, 2'b00);
        check_eq("release_audio", audio, 32'h0);

        // Retrigger during release at level 512
        key_on = 2'b01;
        next_cyc(8);
        key_on = 2'b00;
        found  = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            next_cyc(1);
            if (mag16(audio[15:0]) == 16'd512) found = 1'b1;
        end
        check_eq("rel512_seen", found, 1'b1);
        key_on = 2'b01;
        next_cyc(1);
        check_eq("retrig_audio0", audio[15:0], 16'hF000);
        check_eq("retrig_active", ch_active, 2'b01);
        next_cyc(5);

        // Asynchronous reset mid-note
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_audio", audio, 32'h0);
        check_eq("async_rst_active", ch_active, 2'b00);
        key_on = 2'b00;
        next_cyc(2);
        rst_n = 1'b1;
        next_cyc(4);

`ifdef TONE_MIX_EN
        // Mix: in phase saturates, opposite phase cancels
        amp = 16'h6000;
        set_div(0, 3);
        set_div(1, 3);
        key_on = 2'b11;
        next_cyc(1);
        next_cyc(1);
        check_eq("mix_in_phase_neg", audio_mix, 16'h8000);
        next_cyc(4);
        check_eq("mix_in_phase_pos", audio_mix, 16'h7FFF);
        key_on = 2'b00;
        next_cyc(70);
        key_on = 2'b01;
        next_cyc(4);
        key_on = 2'b11;
        next_cyc(2);
        check_eq("mix_anti_phase", audio_mix, 16'h0000);
        next_cyc(8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
